// File: rtl/det_seq_ctrl.sv
// det_seq_ctrl: table-driven stimulus/check sequencer for a fixed-point model under test
module det_seq_ctrl #(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_in_code,
  input  logic [WIDTH-1:0] cfg_exp_code,
  input  logic [15:0]      hold_cycles,
  input  logic [WIDTH-1:0] tol,
  input  logic [AW:0]      num_steps,
  input  logic             start,
  output logic             model_rst,
  output logic [WIDTH-1:0] v_in_code,
  input  logic [WIDTH-1:0] v_out_code,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      pass_cnt,
  output logic [AW:0]      fail_cnt,
  output logic             first_fail_valid,
  output logic [AW-1:0]    first_fail_idx
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RESET, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] tbl_in [DEPTH];
  logic [WIDTH-1:0] tbl_exp [DEPTH];
  logic model_rst_q, model_rst_d, busy_q, busy_d, done_q, done_d, ffv_q, ffv_d;
  logic [WIDTH-1:0] v_in_q, v_in_d, tol_q, tol_d, exp_code;
  logic [AW:0] pass_q, pass_d, fail_q, fail_d, steps_q, steps_d, nxt;
  logic [AW-1:0] ffi_q, ffi_d, idx_q, idx_d;
  logic [15:0] hcnt_q, hcnt_d, hold_q, hold_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic signed [WIDTH:0] diff;
  logic [WIDTH:0] mag;
  logic ok, last, wr;
  // one extra bit keeps |out - exp| exact across the full signed range
  always_comb begin
    exp_code = tbl_exp[idx_q];
    diff = $signed({v_out_code[WIDTH-1], v_out_code}) - $signed({exp_code[WIDTH-1], exp_code});
    mag = diff[WIDTH] ? -diff : diff;
    ok = mag <= {1'b0, tol_q};
    nxt = {1'b0, idx_q} + (AW+1)'(1);
    last = nxt >= steps_q;
    state_d = state_q;
    model_rst_d = model_rst_q;
    v_in_d = v_in_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    fail_d = fail_q;
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    idx_d = idx_q;
    hcnt_d = hcnt_q;
    hold_d = hold_q;
    tol_d = tol_q;
    steps_d = steps_q;
    rcnt_d = rcnt_q;
    wr = 1'b0;
    case (state_q)
      IDLE: begin
        model_rst_d = 1'b1;
        wr = cfg_we && !start;
        if (start) begin
          state_d = RESET;
          hold_d = hold_cycles == 16'd0 ? 16'd1 : hold_cycles;
          tol_d = tol;
          steps_d = num_steps > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : num_steps;
          pass_d = '0;
          fail_d = '0;
          ffv_d = 1'b0;
          ffi_d = '0;
          busy_d = 1'b1;
          v_in_d = tbl_in[0];
          idx_d = '0;
          rcnt_d = '0;
        end
      end
      RESET: begin
        rcnt_d = rcnt_q + RW'(1);
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          hcnt_d = '0;
          state_d = steps_q == '0 ? DONE : HOLD;
          model_rst_d = steps_q == '0;
          busy_d = steps_q != '0;
          done_d = steps_q == '0;
        end
      end
      HOLD: begin
        hcnt_d = hcnt_q + 16'd1;
        if (hcnt_q == hold_q - 16'd1) begin
          pass_d = ok ? pass_q + (AW+1)'(1) : pass_q;
          fail_d = ok ? fail_q : fail_q + (AW+1)'(1);
          ffv_d = ffv_q || !ok;
          ffi_d = (!ok && !ffv_q) ? idx_q : ffi_q;
          if (last) begin
            state_d = DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
            model_rst_d = 1'b1;
          end else begin
            idx_d = nxt[AW-1:0];
            v_in_d = tbl_in[nxt[AW-1:0]];
            hcnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      model_rst_q <= 1'b1;
      v_in_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= '0;
      fail_q <= '0;
      ffv_q <= 1'b0;
      ffi_q <= '0;
      idx_q <= '0;
      hcnt_q <= '0;
      hold_q <= 16'd1;
      tol_q <= '0;
      steps_q <= '0;
      rcnt_q <= '0;
    end else begin
      state_q <= state_d;
      model_rst_q <= model_rst_d;
      v_in_q <= v_in_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
      idx_q <= idx_d;
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
      tol_q <= tol_d;
      steps_q <= steps_d;
      rcnt_q <= rcnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      tbl_in[cfg_addr] <= cfg_in_code;
      tbl_exp[cfg_addr] <= cfg_exp_code;
    end
  end
  assign model_rst = model_rst_q;
  assign v_in_code = v_in_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx = ffi_q;
endmodule

// File: tb/tb_det_seq_ctrl.sv
// tb_det_seq_ctrl: randomized scoreboard bench for det_seq_ctrl
module tb_det_seq_ctrl;
  localparam int W = 18;
  localparam int D = 16;
  localparam int R = 4;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst, cfg_we, start, model_rst, busy, done, first_fail_valid;
  logic [AW-1:0] cfg_addr, first_fail_idx;
  logic [W-1:0] cfg_in_code, cfg_exp_code, tol, v_in_code, v_out_code;
  logic [15:0] hold_cycles;
  logic [AW:0] num_steps, pass_cnt, fail_cnt;
  typedef struct {int p; int f; int fv; int fi; int t;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int mem_in[D], mem_exp[D], out_arr[D];

  det_seq_ctrl #(.WIDTH(W), .DEPTH(D), .RST_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_in_code(cfg_in_code),
    .cfg_exp_code(cfg_exp_code), .hold_cycles(hold_cycles), .tol(tol), .num_steps(num_steps),
    .start(start), .model_rst(model_rst), .v_in_code(v_in_code), .v_out_code(v_out_code),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx));

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_model_rst"}, model_rst, 1);
    chk({tag, "_v_in"}, v_in_code, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass_cnt, 0);
    chk({tag, "_fail"}, fail_cnt, 0);
    chk({tag, "_ffv"}, first_fail_valid, 0);
    chk({tag, "_ffi"}, first_fail_idx, 0);
  endtask

  // monitor: every done pulse must match the oldest pending run
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending run (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.t);
          chk("pass_cnt", pass_cnt, e.p);
          chk("fail_cnt", fail_cnt, e.f);
          chk("first_fail_valid", first_fail_valid, e.fv);
          chk("first_fail_idx", first_fail_idx, e.fi);
          chk("busy_at_done", busy, 0);
          chk("model_rst_at_done", model_rst, 1);
        end
      end
    end
  end

  task automatic wr(input int a, input int vi, input int ve);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_in_code = W'(vi);
    cfg_exp_code = W'(ve);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    mem_in[a] = vi;
    mem_exp[a] = ve;
  endtask

  task automatic run(input int n_raw, input int h_raw, input int t, input bit rnd,
                     input bit we_start, input bit poke, input bit abort);
    int n, h, p, f, fi, d, k;
    exp_t e;
    n = n_raw > D ? D : n_raw;
    h = h_raw == 0 ? 1 : h_raw;
    p = 0; f = 0; fi = 0;
    for (int i = 0; i < n; i++) begin
      out_arr[i] = rnd ? mem_exp[i] + int'($urandom_range(0, 40)) - 20 : mem_in[i];
      d = out_arr[i] - mem_exp[i];
      if (d < 0) d = -d;
      if (d <= t) p++;
      else begin
        if (f == 0) fi = i;
        f++;
      end
    end
    hold_cycles = 16'(h_raw);
    tol = W'(t);
    num_steps = (AW+1)'(n_raw);
    start = 1'b1;
    if (we_start) begin
      cfg_we = 1'b1;
      cfg_addr = '0;
      cfg_in_code = W'(mem_in[0] + 7);
      cfg_exp_code = W'(mem_exp[0] + 7);
    end
    v_out_code = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_we = 1'b0;
    k = cyc;
    if (!abort) begin
      e = '{p, f, int'(f > 0), fi, k + R + n * h};
      sb.push_back(e);
    end
    chk("busy_at_start", busy, 1);
    chk("v_in_at_start", $signed(v_in_code), mem_in[0]);
    chk("pass_cleared", pass_cnt, 0);
    chk("fail_cleared", fail_cnt, 0);
    chk("ffv_cleared", first_fail_valid, 0);
    chk("model_rst_start", model_rst, 1);
    repeat (R - 1) begin
      @(posedge clk);
      #1;
      chk("model_rst_hold", model_rst, 1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      chk("model_rst_run", model_rst, 0);
      chk("v_in_step", $signed(v_in_code), mem_in[i]);
      v_out_code = W'(out_arr[i]);
      if (abort && i == 1) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset("abort");
        repeat (R + 2 * n * h + 4) @(posedge clk);
        #1;
        chk("abort_stays_idle", busy, 0);
        return;
      end
      if (poke && i == 1 && h >= 2) begin
        start = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = AW'(n - 1);
        cfg_in_code = W'(mem_in[n-1] + 1);
        cfg_exp_code = W'(mem_exp[n-1] + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_we = 1'b0;
        chk("busy_poke", busy, 1);
        repeat (h - 1) @(posedge clk);
      end else repeat (h) @(posedge clk);
      #1;
    end
    #1;
    chk("done_seen", sb.size(), 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("held_pass", pass_cnt, p);
    chk("held_fail", fail_cnt, f);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_in_code = '0;
    cfg_exp_code = '0; hold_cycles = 16'd1; tol = '0; num_steps = '0; v_out_code = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    wr(0, 100, 100); wr(1, -200, -200); wr(2, 300, 300); wr(3, 0, 0);
    run(4, 5, 0, 0, 0, 0, 0);
    wr(2, 300, 310);
    run(4, 5, 5, 0, 0, 0, 0);
    run(4, 5, 10, 0, 0, 0, 0);
    wr(0, -131072, 131071);
    run(1, 2, 10, 0, 0, 0, 0);
    run(1, 2, 262143, 0, 0, 0, 0);
    run(0, 3, 0, 0, 0, 0, 0);
    for (int a = 0; a < D; a++) wr(a, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
    run(20, 2, int'($urandom_range(0, 20)), 1, 0, 0, 0);
    run(4, 4, 10, 1, 0, 0, 1);
    run(4, 4, 10, 1, 0, 0, 0);
    run(4, 5, 10, 1, 1, 0, 0);
    run(4, 3, 10, 1, 0, 1, 0);
    run(3, 0, 5, 1, 0, 0, 0);
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 16)), int'($urandom_range(0, 4)), int'($urandom_range(0, 20)), 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
